// File: rtl/cr_fifoctrl_sync_if.sv
// Handshake, status and address bundle between a FIFO user and cr_fifoctrl_sync.
// The master drives requests and thresholds; the slave (controller) returns addresses and flags.
interface cr_fifoctrl_sync_if #(
    parameter int unsigned pAddrSize = 3
);
    logic                 Flush;
    logic                 WrEn;
    logic                 RdEn;
    logic                 ErrClr;
    logic [pAddrSize:0]   AfThresh;
    logic [pAddrSize:0]   AeThresh;
    logic [pAddrSize-1:0] WrAddr;
    logic [pAddrSize-1:0] RdAddr;
    logic                 WrAccept;
    logic                 RdAccept;
    logic                 Full;
    logic                 Empty;
    logic                 AlmostFull;
    logic                 AlmostEmpty;
    logic [pAddrSize:0]   Level;
    logic                 Overflow;
    logic                 Underflow;

    modport master (
        output Flush, WrEn, RdEn, ErrClr, AfThresh, AeThresh,
        input  WrAddr, RdAddr, WrAccept, RdAccept, Full, Empty,
               AlmostFull, AlmostEmpty, Level, Overflow, Underflow
    );

    modport slave (
        input  Flush, WrEn, RdEn, ErrClr, AfThresh, AeThresh,
        output WrAddr, RdAddr, WrAccept, RdAccept, Full, Empty,
               AlmostFull, AlmostEmpty, Level, Overflow, Underflow
    );
endinterface

// File: rtl/cr_fifoctrl_sync.sv
// Single-clock FIFO controller for an external dual-port RAM of pDepth entries:
// pointer generation with arbitrary-depth wrap, level tracking, status and sticky error flags.
module cr_fifoctrl_sync #(
    parameter int unsigned pAddrSize = 3,
    parameter int unsigned pDepth    = 8
) (
    input logic               Clk,
    input logic               Rst_n,
    cr_fifoctrl_sync_if.slave fifoBus
);
    localparam int unsigned cLvlW = pAddrSize + 1;
    localparam logic [pAddrSize-1:0] cLastAddr = pAddrSize'(pDepth - 1);
    localparam logic [cLvlW-1:0]     cFullLvl  = cLvlW'(pDepth);

    logic [pAddrSize-1:0] wrAddrQ, wrAddrD;
    logic [pAddrSize-1:0] rdAddrQ, rdAddrD;
    logic [cLvlW-1:0]     levelQ, levelD;
    logic                 fullQ, fullD;
    logic                 emptyQ, emptyD;
    logic                 overflowQ, overflowD;
    logic                 underflowQ, underflowD;
    logic                 wrAccept, rdAccept;

    // Wrap by compare so non-power-of-two depths work.
    function automatic logic [pAddrSize-1:0] nextAddr(input logic [pAddrSize-1:0] addr);
        return (addr == cLastAddr) ? '0 : addr + pAddrSize'(1);
    endfunction

    always_comb begin
        wrAccept = fifoBus.WrEn & ~fullQ & ~fifoBus.Flush;
        rdAccept = fifoBus.RdEn & ~emptyQ & ~fifoBus.Flush;
        wrAddrD  = wrAddrQ;
        rdAddrD  = rdAddrQ;
        levelD   = levelQ;

        if (fifoBus.Flush) begin
            wrAddrD = '0;
            rdAddrD = '0;
            levelD  = '0;
        end else begin
            if (wrAccept) wrAddrD = nextAddr(wrAddrQ);
            if (rdAccept) rdAddrD = nextAddr(rdAddrQ);
            case ({wrAccept, rdAccept})
                2'b10:   levelD = levelQ + cLvlW'(1);
                2'b01:   levelD = levelQ - cLvlW'(1);
                default: levelD = levelQ;
            endcase
        end

        // Flags load from the next level so they never lag Level.
        fullD  = (levelD == cFullLvl);
        emptyD = (levelD == '0);

        // A new error event in the same cycle wins over the clear.
        overflowD  = (overflowQ & ~fifoBus.ErrClr) | (fifoBus.WrEn & fullQ & ~fifoBus.Flush);
        underflowD = (underflowQ & ~fifoBus.ErrClr) | (fifoBus.RdEn & emptyQ & ~fifoBus.Flush);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wrAddrQ    <= '0;
            rdAddrQ    <= '0;
            levelQ     <= '0;
            fullQ      <= 1'b0;
            emptyQ     <= 1'b1;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            wrAddrQ    <= wrAddrD;
            rdAddrQ    <= rdAddrD;
            levelQ     <= levelD;
            fullQ      <= fullD;
            emptyQ     <= emptyD;
            overflowQ  <= overflowD;
            underflowQ <= underflowD;
        end
    end

    assign fifoBus.WrAddr      = wrAddrQ;
    assign fifoBus.RdAddr      = rdAddrQ;
    assign fifoBus.WrAccept    = wrAccept;
    assign fifoBus.RdAccept    = rdAccept;
    assign fifoBus.Full        = fullQ;
    assign fifoBus.Empty       = emptyQ;
    assign fifoBus.Level       = levelQ;
    assign fifoBus.Overflow    = overflowQ;
    assign fifoBus.Underflow   = underflowQ;
    // Thresholds are live inputs, so these follow threshold changes in the same cycle.
    assign fifoBus.AlmostFull  = (levelQ >= fifoBus.AfThresh);
    assign fifoBus.AlmostEmpty = (levelQ <= fifoBus.AeThresh);
endmodule

// File: tb/tb_cr_fifoctrl_sync.sv
// Bench for cr_fifoctrl_sync: four controllers (depths 6, 2, 5, 8) share one stimulus stream
// and are checked every cycle against a queue model, plus directed literal checks on depth 6.
module tb_cr_fifoctrl_sync;
    localparam int unsigned cAw  = 3;
    localparam int unsigned cLw  = cAw + 1;
    localparam int unsigned cNum = 4;

    function automatic int unsigned depthOf(input int unsigned idx);
        case (idx)
            0:       return 6;
            1:       return 2;
            2:       return 5;
            default: return 8;
        endcase
    endfunction

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic           flush, wrEn, rdEn, errClr;
    logic [cLw-1:0] afThresh, aeThresh;

    logic [cAw-1:0] dWrAddr[cNum];
    logic [cAw-1:0] dRdAddr[cNum];
    logic [cLw-1:0] dLevel[cNum];
    logic           dWrAcc[cNum];
    logic           dRdAcc[cNum];
    logic           dFull[cNum];
    logic           dEmpty[cNum];
    logic           dAf[cNum];
    logic           dAe[cNum];
    logic           dOvf[cNum];
    logic           dUnf[cNum];

    int vecCnt = 0;
    int errCnt = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < cNum; g++) begin : gDut
        cr_fifoctrl_sync_if #(.pAddrSize(cAw)) bus ();

        assign bus.Flush    = flush;
        assign bus.WrEn     = wrEn;
        assign bus.RdEn     = rdEn;
        assign bus.ErrClr   = errClr;
        assign bus.AfThresh = afThresh;
        assign bus.AeThresh = aeThresh;
        assign dWrAddr[g]   = bus.WrAddr;
        assign dRdAddr[g]   = bus.RdAddr;
        assign dLevel[g]    = bus.Level;
        assign dWrAcc[g]    = bus.WrAccept;
        assign dRdAcc[g]    = bus.RdAccept;
        assign dFull[g]     = bus.Full;
        assign dEmpty[g]    = bus.Empty;
        assign dAf[g]       = bus.AlmostFull;
        assign dAe[g]       = bus.AlmostEmpty;
        assign dOvf[g]      = bus.Overflow;
        assign dUnf[g]      = bus.Underflow;

        cr_fifoctrl_sync #(
            .pAddrSize(cAw),
            .pDepth   (depthOf(g))
        ) dut (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .fifoBus(bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Model: a queue of written addresses per controller; pointers are total accepts mod depth.
    int unsigned mQ[cNum][$];
    int unsigned mWrCnt[cNum];
    int unsigned mRdCnt[cNum];
    bit          mOvf[cNum];
    bit          mUnf[cNum];
    bit          mValid = 1'b0;
    int unsigned dep, lvl, popped;
    bit          expWa, expRa;
    string       tag;

    always @(negedge Clk) begin
        for (int i = 0; i < cNum; i++) begin
            dep   = depthOf(i);
            lvl   = mQ[i].size();
            expWa = wrEn && !flush && (lvl < dep);
            expRa = rdEn && !flush && (lvl > 0);
            tag   = $sformatf("d%0d", dep);
            if (mValid) begin
                check({tag, " Level"},       dLevel[i],  lvl);
                check({tag, " Full"},        dFull[i],   lvl == dep);
                check({tag, " Empty"},       dEmpty[i],  lvl == 0);
                check({tag, " WrAccept"},    dWrAcc[i],  expWa);
                check({tag, " RdAccept"},    dRdAcc[i],  expRa);
                check({tag, " AlmostFull"},  dAf[i],     lvl >= afThresh);
                check({tag, " AlmostEmpty"}, dAe[i],     lvl <= aeThresh);
                check({tag, " WrAddr"},      dWrAddr[i], mWrCnt[i] % dep);
                check({tag, " RdAddr"},      dRdAddr[i], mRdCnt[i] % dep);
                check({tag, " Overflow"},    dOvf[i],    mOvf[i]);
                check({tag, " Underflow"},   dUnf[i],    mUnf[i]);
            end
            if (!Rst_n) begin
                mQ[i].delete();
                mWrCnt[i] = 0;
                mRdCnt[i] = 0;
                mOvf[i]   = 1'b0;
                mUnf[i]   = 1'b0;
            end else begin
                mOvf[i] = (mOvf[i] && !errClr) || (wrEn && !flush && lvl == dep);
                mUnf[i] = (mUnf[i] && !errClr) || (rdEn && !flush && lvl == 0);
                if (flush) begin
                    mQ[i].delete();
                    mWrCnt[i] = 0;
                    mRdCnt[i] = 0;
                end else begin
                    if (expRa) begin
                        popped = mQ[i].pop_front();
                        mRdCnt[i]++;
                        if (mValid) check({tag, " read slot"}, dRdAddr[i], popped);
                    end
                    if (expWa) begin
                        mQ[i].push_back(mWrCnt[i] % dep);
                        mWrCnt[i]++;
                    end
                end
            end
        end
        if (!Rst_n) mValid = 1'b1;
    end

    initial begin
        logic [6:0]  afTab;
        logic [6:0]  aeTab;
        int unsigned wp, rp;

        Rst_n = 1'b0; flush = 1'b0; wrEn = 1'b1; rdEn = 1'b1; errClr = 1'b0;
        afThresh = 4'd4; aeThresh = 4'd1;
        tick();
        tick();
        Rst_n = 1'b1;
        #1;
        check("rst Empty", dEmpty[0], 1);
        check("rst Full", dFull[0], 0);
        check("rst Level", dLevel[0], 0);
        check("rst WrAddr", dWrAddr[0], 0);
        check("rst RdAddr", dRdAddr[0], 0);
        check("rst Underflow", dUnf[0], 0);
        check("rst Overflow", dOvf[0], 0);
        check("rst AlmostEmpty", dAe[0], 1);
        check("rst AlmostFull", dAf[0], 0);
        check("rst RdAccept", dRdAcc[0], 0);
        check("rst WrAccept", dWrAcc[0], 1);
        tick();
        check("first Underflow", dUnf[0], 1);
        check("first Level", dLevel[0], 1);
        check("first WrAddr", dWrAddr[0], 1);
        wrEn = 1'b0; rdEn = 1'b0; errClr = 1'b1;
        tick();
        errClr = 1'b0;
        check("clr Underflow", dUnf[0], 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush0 Level", dLevel[0], 0);
        check("flush0 WrAddr", dWrAddr[0], 0);

        // Fill depth 6 with AfThresh=4, AeThresh=1; bit k = flag at level k.
        afTab = 7'b1110000;
        aeTab = 7'b0000011;
        wrEn  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            #1;
            check("fill AlmostFull", dAf[0], afTab[i-1]);
            check("fill AlmostEmpty", dAe[0], aeTab[i-1]);
            tick();
            check("fill Level", dLevel[0], i);
            check("fill Full", dFull[0], i == 6);
            check("fill WrAddr", dWrAddr[0], i % 6);
        end
        #1;
        check("full AlmostFull", dAf[0], 1);
        check("7th WrAccept", dWrAcc[0], 0);
        tick();
        check("7th Overflow", dOvf[0], 1);
        check("7th Level", dLevel[0], 6);
        check("7th WrAddr", dWrAddr[0], 0);

        rdEn = 1'b1;
        #1;
        check("both@full RdAccept", dRdAcc[0], 1);
        check("both@full WrAccept", dWrAcc[0], 0);
        tick();
        check("both@full Level", dLevel[0], 5);
        check("both@full Full", dFull[0], 0);
        check("both@full RdAddr", dRdAddr[0], 1);
        check("both@full WrAddr", dWrAddr[0], 0);
        check("both@full Overflow", dOvf[0], 1);
        tick();
        check("both Level", dLevel[0], 5);
        check("both RdAddr", dRdAddr[0], 2);
        check("both WrAddr", dWrAddr[0], 1);

        wrEn = 1'b0;
        for (int l = 5; l >= 1; l--) begin
            #1;
            check("drain AlmostFull", dAf[0], afTab[l]);
            check("drain AlmostEmpty", dAe[0], aeTab[l]);
            tick();
            check("drain Level", dLevel[0], l - 1);
        end
        check("drained Empty", dEmpty[0], 1);
        check("drained RdAddr", dRdAddr[0], 1);

        rdEn = 1'b0; wrEn = 1'b1;
        tick(); tick(); tick();
        check("refill Level", dLevel[0], 3);
        check("refill WrAddr", dWrAddr[0], 4);
        flush = 1'b1;
        #1;
        check("flush WrAccept", dWrAcc[0], 0);
        tick();
        flush = 1'b0; wrEn = 1'b0;
        check("flush Level", dLevel[0], 0);
        check("flush Empty", dEmpty[0], 1);
        check("flush WrAddr", dWrAddr[0], 0);
        check("flush RdAddr", dRdAddr[0], 0);
        check("flush Overflow kept", dOvf[0], 1);
        rdEn = 1'b1;
        tick();
        check("empty-read Underflow", dUnf[0], 1);
        errClr = 1'b1;
        tick();
        check("set-beats-clear Underflow", dUnf[0], 1);
        check("clear Overflow", dOvf[0], 0);
        rdEn = 1'b0;
        tick();
        errClr = 1'b0;
        check("clear Underflow", dUnf[0], 0);

        afThresh = 4'd0; aeThresh = 4'd7;
        #1;
        check("Af0 AlmostFull", dAf[0], 1);
        check("Ae7 AlmostEmpty", dAe[0], 1);
        afThresh = 4'd7; aeThresh = 4'd6;
        wrEn = 1'b1;
        repeat (6) tick();
        wrEn = 1'b0;
        #1;
        check("Af7 full", dFull[0], 1);
        check("Af7 AlmostFull", dAf[0], 0);
        check("Ae6 AlmostEmpty", dAe[0], 1);
        aeThresh = 4'd5; afThresh = 4'd6;
        #1;
        check("Ae5 AlmostEmpty", dAe[0], 0);
        check("Af6 AlmostFull", dAf[0], 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        wp = 50; rp = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 256 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            if (c % 37 == 0) begin
                afThresh = cLw'($urandom_range(0, 9));
                aeThresh = cLw'($urandom_range(0, 9));
            end
            wrEn   = ($urandom_range(0, 99) < wp);
            rdEn   = ($urandom_range(0, 99) < rp);
            flush  = ($urandom_range(0, 99) == 0);
            errClr = ($urandom_range(0, 49) == 0);
            Rst_n  = (c != 5000);
            tick();
        end
        Rst_n = 1'b1; wrEn = 1'b0; rdEn = 1'b0; flush = 1'b0; errClr = 1'b0;
        tick();
        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule
